// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, operand select, 64-bit ALU,
// condition-code register and branch/cmov condition evaluation.
module execute_stage #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [3:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic [3:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic [WIDTH-1:0] e_valE,
  output logic [WIDTH-1:0] e_valA,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       cc
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;

  localparam logic [WIDTH-1:0] PLUS8  = {{(WIDTH-4){1'b0}}, 4'b1000};
  localparam logic [WIDTH-1:0] MINUS8 = {{(WIDTH-4){1'b1}}, 4'b1000};

  logic [3:0]       stat_reg, icode_reg, ifun_reg;
  logic [WIDTH-1:0] valc_reg, vala_reg, valb_reg;
  logic [3:0]       dste_reg, dstm_reg, srca_reg, srcb_reg;
  logic [2:0]       cc_reg, cc_next;

  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [3:0]       alu_fun;
  logic             set_cc, alu_of, zf, sf, of;

  // E register: bubble takes priority over stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_reg  <= S_AOK;
      icode_reg <= I_NOP;
      ifun_reg  <= 4'h0;
      valc_reg  <= '0;
      vala_reg  <= '0;
      valb_reg  <= '0;
      dste_reg  <= RNONE;
      dstm_reg  <= RNONE;
      srca_reg  <= RNONE;
      srcb_reg  <= RNONE;
    end else if (E_bubble) begin
      stat_reg  <= S_AOK;
      icode_reg <= I_NOP;
      ifun_reg  <= 4'h0;
      valc_reg  <= '0;
      vala_reg  <= '0;
      valb_reg  <= '0;
      dste_reg  <= RNONE;
      dstm_reg  <= RNONE;
      srca_reg  <= RNONE;
      srcb_reg  <= RNONE;
    end else if (!E_stall) begin
      stat_reg  <= d_stat;
      icode_reg <= d_icode;
      ifun_reg  <= d_ifun;
      valc_reg  <= d_valC;
      vala_reg  <= d_valA;
      valb_reg  <= d_valB;
      dste_reg  <= d_dstE;
      dstm_reg  <= d_dstM;
      srca_reg  <= d_srcA;
      srcb_reg  <= d_srcB;
    end
  end

  always_comb begin
    alu_a = '0;
    unique case (icode_reg)
      I_RRMOVQ, I_OPQ:             alu_a = vala_reg;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valc_reg;
      I_CALL, I_PUSHQ:             alu_a = MINUS8;
      I_RET, I_POPQ:               alu_a = PLUS8;
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (icode_reg)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
      I_PUSHQ, I_RET, I_POPQ:      alu_b = valb_reg;
      default:                     alu_b = '0;
    endcase
  end

  assign alu_fun = (icode_reg == I_OPQ) ? ifun_reg : 4'h0;

  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    unique case (alu_fun)
      4'h0: begin
        alu_r  = alu_b + alu_a;
        alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'h1: begin
        alu_r  = alu_b - alu_a;
        alu_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      4'h2:    alu_r = alu_b & alu_a;
      4'h3:    alu_r = alu_b ^ alu_a;
      default: alu_r = '0;
    endcase
  end

  // Undefined OPq functions leave the flags alone
  assign set_cc  = (icode_reg == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK)
                   && (ifun_reg <= 4'h3);
  assign cc_next = {alu_r == '0, alu_r[WIDTH-1], alu_of};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cc_reg <= 3'b100;
    else if (set_cc)
      cc_reg <= cc_next;
  end

  assign zf = cc_reg[2];
  assign sf = cc_reg[1];
  assign of = cc_reg[0];

  always_comb begin
    e_Cnd = 1'b0;
    unique case (ifun_reg)
      4'h0:    e_Cnd = 1'b1;
      4'h1:    e_Cnd = (sf ^ of) | zf;
      4'h2:    e_Cnd = sf ^ of;
      4'h3:    e_Cnd = zf;
      4'h4:    e_Cnd = ~zf;
      4'h5:    e_Cnd = ~(sf ^ of);
      4'h6:    e_Cnd = ~(sf ^ of) & ~zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE  = ((icode_reg == I_RRMOVQ) && !e_Cnd) ? RNONE : dste_reg;
  assign e_valE  = alu_r;
  assign e_valA  = vala_reg;
  assign cc      = cc_reg;
  assign E_stat  = stat_reg;
  assign E_icode = icode_reg;
  assign E_ifun  = ifun_reg;
  assign E_dstM  = dstm_reg;
  assign E_srcA  = srca_reg;
  assign E_srcB  = srcb_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, operand select, CC update/suppression,
// conditions, stall/bubble priority and asynchronous reset.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        E_stall = 1'b0, E_bubble = 1'b0;
  logic [3:0]  d_stat = 4'h1, d_icode = 4'h1, d_ifun = 4'h0;
  logic [63:0] d_valC = '0, d_valA = '0, d_valB = '0;
  logic [3:0]  d_dstE = 4'hF, d_dstM = 4'hF, d_srcA = 4'hF, d_srcB = 4'hF;
  logic [3:0]  m_stat = 4'h1, W_stat = 4'h1;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstM, E_srcA, E_srcB, e_dstE;
  logic [63:0] e_valE, e_valA;
  logic        e_Cnd;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clock(clock), .reset(reset), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] valC, input logic [63:0] valA,
                       input logic [63:0] valB, input logic [3:0] dstE,
                       input logic [3:0] dstM, input logic [3:0] srcA,
                       input logic [3:0] srcB);
    d_icode = icode; d_ifun = ifun;
    d_valC = valC; d_valA = valA; d_valB = valB;
    d_dstE = dstE; d_dstM = dstM; d_srcA = srcA; d_srcB = srcB;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    drive(4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
  endtask

  initial begin
    // Reset held low across a clock edge
    #12;
    check("rst_icode", 64'(E_icode), 64'h1);
    check("rst_stat",  64'(E_stat),  64'h1);
    check("rst_dstM",  64'(E_dstM),  64'hF);
    check("rst_srcA",  64'(E_srcA),  64'hF);
    check("rst_srcB",  64'(E_srcB),  64'hF);
    check("rst_dstE",  64'(e_dstE),  64'hF);
    check("rst_cc",    64'(cc),      64'h4);
    check("rst_valE",  e_valE,       64'h0);
    reset = 1'b1;

    // ADD 3+5
    drive(4'h6, 4'h0, 0, 64'd3, 64'd5, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("add_valE",  e_valE, 64'd8);
    check("add_icode", 64'(E_icode), 64'h6);
    nop(); step();
    check("add_cc", 64'(cc), 64'h0);

    // SUB overflow
    drive(4'h6, 4'h1, 0, 64'd1, 64'h8000_0000_0000_0000, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("sub_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    nop(); step();
    check("sub_cc", 64'(cc), 64'h1);

    // CC suppressed by a faulting downstream stage
    m_stat = 4'h3;
    drive(4'h6, 4'h0, 0, 64'd3, 64'd5, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("mstat_valE", e_valE, 64'd8);
    nop(); step();
    check("mstat_cc", 64'(cc), 64'h1);
    m_stat = 4'h1; W_stat = 4'h2;
    drive(4'h6, 4'h0, 0, 64'd3, 64'd5, 4'h2, 4'hF, 4'h1, 4'h2);
    step(); nop(); step();
    check("wstat_cc", 64'(cc), 64'h1);
    W_stat = 4'h1;

    // AND / XOR
    drive(4'h6, 4'h2, 0, 64'hF0, 64'h3C, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("and_valE", e_valE, 64'h30);
    drive(4'h6, 4'h3, 0, 64'hF0, 64'h3C, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("xor_valE", e_valE, 64'hCC);
    check("and_cc", 64'(cc), 64'h0);

    // cmov le with cc=000: not taken
    drive(4'h6, 4'h0, 0, 64'd3, 64'd5, 4'h2, 4'hF, 4'h1, 4'h2);
    step(); nop(); step();
    check("pre_cmov_cc", 64'(cc), 64'h0);
    drive(4'h2, 4'h1, 0, 64'd7, 0, 4'h2, 4'hF, 4'h1, 4'hF);
    step();
    check("cmov_cnd0",  64'(e_Cnd),  64'h0);
    check("cmov_dstE0", 64'(e_dstE), 64'hF);
    check("cmov_valE",  e_valE,      64'd7);

    // SUB 5-5 sets ZF, cmov le now taken
    drive(4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("sub0_valE", e_valE, 64'h0);
    nop(); step();
    check("zf_cc", 64'(cc), 64'h4);
    drive(4'h2, 4'h1, 0, 64'd7, 0, 4'h2, 4'hF, 4'h1, 4'hF);
    step();
    check("cmov_cnd1",  64'(e_Cnd),  64'h1);
    check("cmov_dstE1", 64'(e_dstE), 64'h2);
    drive(4'h7, 4'h4, 64'h40, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
    step();
    check("jne_cnd", 64'(e_Cnd), 64'h0);
    check("jne_valE", e_valE, 64'h0);

    // Undefined ALU function: zero result, CC untouched
    drive(4'h6, 4'h4, 0, 64'd3, 64'd5, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    check("bad_fun_valE", e_valE, 64'h0);
    nop(); step();
    check("bad_fun_cc", 64'(cc), 64'h4);

    // Address arithmetic
    drive(4'h3, 4'h0, 64'h1234, 0, 64'h999, 4'h3, 4'hF, 4'hF, 4'hF);
    step();
    check("irmov_valE", e_valE, 64'h1234);
    drive(4'h4, 4'h0, 64'h10, 64'h77, 64'h20, 4'hF, 4'hF, 4'h1, 4'h2);
    step();
    check("rmmov_valE", e_valE, 64'h30);
    drive(4'hA, 4'h0, 0, 64'h55, 64'h100, 4'h4, 4'hF, 4'h6, 4'h4);
    step();
    check("push_valE", e_valE, 64'hF8);
    drive(4'hB, 4'h0, 0, 64'h55, 64'h100, 4'h4, 4'h5, 4'h6, 4'h4);
    step();
    check("pop_valE", e_valE, 64'h108);
    check("pop_valA", e_valA, 64'h55);

    // Stall holds, bubble beats stall
    E_stall = 1'b1; d_stat = 4'h3;
    drive(4'h3, 4'h0, 64'hABC, 64'h1, 64'h2, 4'h1, 4'h1, 4'h1, 4'h1);
    step();
    check("stall_icode", 64'(E_icode), 64'hB);
    check("stall_dstM",  64'(E_dstM),  64'h5);
    check("stall_srcA",  64'(E_srcA),  64'h6);
    check("stall_valE",  e_valE,       64'h108);
    check("stall_stat",  64'(E_stat),  64'h1);
    E_bubble = 1'b1;
    step();
    check("bub_icode", 64'(E_icode), 64'h1);
    check("bub_stat",  64'(E_stat),  64'h1);
    check("bub_dstM",  64'(E_dstM),  64'hF);
    check("bub_dstE",  64'(e_dstE),  64'hF);
    check("bub_valE",  e_valE,       64'h0);
    E_stall = 1'b0; E_bubble = 1'b0; d_stat = 4'h1;

    // Back-to-back OPq, then async reset with an update pending
    drive(4'h6, 4'h1, 0, 64'd1, 64'h8000_0000_0000_0000, 4'h2, 4'hF, 4'h1, 4'h2);
    step();
    drive(4'h6, 4'h0, 0, 64'd3, 64'd5, 4'h2, 4'h7, 4'h1, 4'h2);
    step();
    check("b2b_cc", 64'(cc), 64'h1);
    check("b2b_valE", e_valE, 64'd8);
    #2;
    reset = 1'b0;
    #1;
    check("arst_icode", 64'(E_icode), 64'h1);
    check("arst_dstM",  64'(E_dstM),  64'hF);
    check("arst_cc",    64'(cc),      64'h4);
    check("arst_valE",  e_valE,       64'h0);
    step();
    check("arst_cc_hold", 64'(cc), 64'h4);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
